// File: rtl/ir_key_event.sv
// NEC frame -> key press/repeat/release events, queued for the display/control logic.
// Optional IR_ADDR_FILTER_EN drops good frames whose address differs from DEV_ADDR.

// Generic synchronous FIFO with count-based full/empty flags.
// Latency: a write is visible on rd_vld the next cycle; rd_dat comes straight from storage.
// Backpressure: wr_rdy low only when full and no read this cycle; a full FIFO accepts a write alongside a read.
module ir_key_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign rd_vld = (count != '0);
  assign wr_rdy = (count != CNT_FULL) | rd_rdy;
  assign wr_en  = wr_vld & wr_rdy;
  assign rd_en  = rd_vld & rd_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// Turns decoded NEC frames and repeat strobes into key events (macro: IR_ADDR_FILTER_EN).
// Latency: frame_valid/repeat_valid -> key_valid is one cycle.
// Backpressure: key_ready stalls the event FIFO; events arriving while it is full are dropped and flag overflow.
module ir_key_event #(
  parameter int         FIFO_DEPTH   = 4,
  parameter int         HOLD_TIMEOUT = 1400,
  parameter logic [7:0] DEV_ADDR     = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  input  logic [31:0] frame,
  input  logic        repeat_valid,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [7:0]  key_code,
  output logic [1:0]  key_kind,
  output logic        held,
  output logic        overflow,
  output logic [7:0]  err_count
);
  localparam logic [1:0] KIND_PRESS   = 2'b00;
  localparam logic [1:0] KIND_REPEAT  = 2'b01;
  localparam logic [1:0] KIND_RELEASE = 2'b10;
  localparam int TW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(HOLD_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [1:0] {IDLE, HELD, SWITCH} state_t;

  state_t        state, state_nxt;
  logic [7:0]    cur_cmd, cur_nxt;
  logic [7:0]    pend_cmd, pend_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          frame_good;
  logic          addr_ok;
  logic          frame_ok;
  logic          rep_ok;
  logic          push_vld;
  logic          push_rdy;
  logic [7:0]    push_code;
  logic [1:0]    push_kind;
  logic [9:0]    head_dat;

  assign frame_good = ((frame[31:24] ^ frame[23:16]) == 8'hFF) &&
                      ((frame[15:8]  ^ frame[7:0])   == 8'hFF);

`ifdef IR_ADDR_FILTER_EN
  assign addr_ok = (frame[31:24] == DEV_ADDR);
`else
  logic unused_dev_addr;
  assign addr_ok = 1'b1;
  assign unused_dev_addr = ^DEV_ADDR;
`endif

  // A frame strobe always masks a simultaneous repeat strobe.
  assign frame_ok = frame_valid & frame_good & addr_ok;
  assign rep_ok   = repeat_valid & ~frame_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cur_cmd  <= 8'h00;
      pend_cmd <= 8'h00;
      timer    <= '0;
    end else begin
      state    <= state_nxt;
      cur_cmd  <= cur_nxt;
      pend_cmd <= pend_nxt;
      timer    <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_cmd;
    pend_nxt  = pend_cmd;
    timer_nxt = timer;
    push_vld  = 1'b0;
    push_code = cur_cmd;
    push_kind = KIND_PRESS;
    case (state)
      IDLE: begin
        if (frame_ok) begin
          push_vld  = 1'b1;
          push_code = frame[15:8];
          cur_nxt   = frame[15:8];
          timer_nxt = '0;
          state_nxt = HELD;
        end
      end
      HELD: begin
        if (frame_ok && frame[15:8] == cur_cmd) begin
          push_vld  = 1'b1;
          push_kind = KIND_REPEAT;
          timer_nxt = '0;
        end else if (frame_ok) begin
          push_vld  = 1'b1;
          push_kind = KIND_RELEASE;
          pend_nxt  = frame[15:8];
          state_nxt = SWITCH;
        end else if (rep_ok) begin
          push_vld  = 1'b1;
          push_kind = KIND_REPEAT;
          timer_nxt = '0;
        end else if (timer == TIMER_LAST) begin
          push_vld  = 1'b1;
          push_kind = KIND_RELEASE;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + TIMER_ONE;
        end
      end
      SWITCH: begin
        push_vld  = 1'b1;
        push_code = pend_cmd;
        cur_nxt   = pend_cmd;
        timer_nxt = '0;
        state_nxt = HELD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      if (frame_valid && !frame_good && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
      if (push_vld && !push_rdy) begin
        overflow <= 1'b1;
      end
    end
  end

  ir_key_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (push_vld),
    .wr_dat ({push_code, push_kind}),
    .wr_rdy (push_rdy),
    .rd_vld (key_valid),
    .rd_rdy (key_ready),
    .rd_dat (head_dat)
  );

  // Head storage is not reset, so present zeros whenever nothing is queued.
  assign key_code = key_valid ? head_dat[9:2] : 8'h00;
  assign key_kind = key_valid ? head_dat[1:0] : 2'b00;
  assign held     = (state == HELD);
endmodule

// File: tb/tb_ir_key_event.sv
// Randomized + directed bench for ir_key_event against a timestamp-based event model.
// Define IR_ADDR_FILTER_EN on both RTL and bench to exercise address filtering.
module tb_ir_key_event;
  localparam int         DEPTH = 4;
  localparam int         HOLD  = 1400;
  localparam logic [7:0] ADDR  = 8'h00;
  localparam logic [1:0] K_PRESS = 2'b00, K_REPEAT = 2'b01, K_RELEASE = 2'b10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_valid = 1'b0;
  logic [31:0] frame = '0;
  logic        repeat_valid = 1'b0;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic [7:0]  key_code;
  logic [1:0]  key_kind;
  logic        held;
  logic        overflow;
  logic [7:0]  err_count;

  ir_key_event #(.FIFO_DEPTH(DEPTH), .HOLD_TIMEOUT(HOLD), .DEV_ADDR(ADDR)) dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .frame(frame),
    .repeat_valid(repeat_valid), .key_valid(key_valid), .key_ready(key_ready),
    .key_code(key_code), .key_kind(key_kind), .held(held), .overflow(overflow),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: key is "held" from a refresh timestamp; release fires HOLD edges later.
  logic [9:0] m_q[$];
  bit         m_holding, m_switch, m_ovf;
  logic [7:0] m_cur, m_pend;
  int         m_tref, m_n, m_err;

  function automatic logic [31:0] mk_frame(input logic [7:0] a, input logic [7:0] c);
    return {a, ~a, c, ~c};
  endfunction

  task automatic model_edge(input logic fv, input logic [31:0] fr, input logic rv,
                            input logic rdy, input logic rst);
    bit         good, accept, ev;
    logic [9:0] e;
    m_n++;
    if (rst) begin
      m_q.delete(); m_holding = 0; m_switch = 0; m_ovf = 0; m_err = 0;
      return;
    end
    good = ((fr[31:24] ^ fr[23:16]) == 8'hFF) && ((fr[15:8] ^ fr[7:0]) == 8'hFF);
`ifdef IR_ADDR_FILTER_EN
    accept = fv && good && (fr[31:24] == ADDR);
`else
    accept = fv && good;
`endif
    if (fv && !good && m_err < 255) m_err++;
    ev = 0; e = '0;
    if (m_switch) begin
      ev = 1; e = {m_pend, K_PRESS}; m_cur = m_pend;
      m_switch = 0; m_holding = 1; m_tref = m_n;
    end else if (!m_holding) begin
      if (accept) begin
        ev = 1; e = {fr[15:8], K_PRESS}; m_cur = fr[15:8];
        m_holding = 1; m_tref = m_n;
      end
    end else if (accept && fr[15:8] == m_cur) begin
      ev = 1; e = {m_cur, K_REPEAT}; m_tref = m_n;
    end else if (accept) begin
      ev = 1; e = {m_cur, K_RELEASE}; m_pend = fr[15:8];
      m_holding = 0; m_switch = 1;
    end else if (rv && !fv) begin
      ev = 1; e = {m_cur, K_REPEAT}; m_tref = m_n;
    end else if (m_n - m_tref == HOLD) begin
      ev = 1; e = {m_cur, K_RELEASE}; m_holding = 0;
    end
    if (rdy && m_q.size() != 0) void'(m_q.pop_front());
    if (ev) begin
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else m_ovf = 1;
    end
  endtask

  task automatic step(input logic fv, input logic [31:0] fr, input logic rv,
                      input logic rdy, input logic rst);
    frame_valid = fv; frame = fr; repeat_valid = rv; key_ready = rdy; reset = rst;
    @(posedge clk);
    model_edge(fv, fr, rv, rdy, rst);
    #1;
    frame_valid = 1'b0; repeat_valid = 1'b0; reset = 1'b0;
    check("key_valid", key_valid, (m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("key_code", key_code, m_q[0][9:2]);
      check("key_kind", key_kind, m_q[0][1:0]);
    end
    check("held", held, m_holding);
    check("overflow", overflow, m_ovf);
    check("err_count", err_count, m_err);
  endtask

  task automatic idle(input int cycles, input logic rdy);
    for (int i = 0; i < cycles; i++) step(1'b0, 32'h0, 1'b0, rdy, 1'b0);
  endtask

  function automatic logic [31:0] bad_frame();
    logic [31:0] f;
    logic [7:0]  nz;
    f  = mk_frame(8'($urandom), 8'($urandom));
    nz = 8'($urandom_range(1, 255));
    if ($urandom_range(1) == 0) f[7:0] = f[7:0] ^ nz;
    else f[23:16] = f[23:16] ^ nz;
    return f;
  endfunction

  initial begin
    logic [1:0] drain_kind [4];
    m_n = 0; m_tref = 0; m_cur = 0; m_pend = 0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_kind", key_kind, 0);
    check("rst_held", held, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", err_count, 0);

    // Press appears one cycle after the strobe.
    step(1'b1, 32'h00FF45BA, 1'b0, 1'b0, 1'b0);
    check("t1_valid", key_valid, 1);
    check("t1_code", key_code, 8'h45);
    check("t1_kind", key_kind, K_PRESS);
    check("t1_held", held, 1);

    // Three repeats 1000 cycles apart, then release after the hold timeout.
    for (int r = 0; r < 3; r++) begin
      idle(999, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      check("t2_rep_kind", key_kind, K_REPEAT);
    end
    idle(HOLD - 1, 1'b1);
    check("t2_still_held", held, 1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("t2_rel_kind", key_kind, K_RELEASE);
    check("t2_rel_code", key_code, 8'h45);
    check("t2_held", held, 0);
    idle(2, 1'b1);

    // New command while held: release old, press new on the next cycle.
    step(1'b1, 32'h00FF45BA, 1'b0, 1'b1, 1'b0);
    idle(5, 1'b1);
    step(1'b1, 32'h00FF16E9, 1'b0, 1'b0, 1'b0);
    check("t3_rel_kind", key_kind, K_RELEASE);
    check("t3_rel_code", key_code, 8'h45);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("t3_prs_kind", key_kind, K_PRESS);
    check("t3_prs_code", key_code, 8'h16);
    idle(HOLD + 3, 1'b1);

    // Complement errors, then saturation.
    step(1'b1, 32'h00FF4545, 1'b0, 1'b1, 1'b0);
    check("t4_err1", err_count, 1);
    check("t4_noevt", key_valid, 0);
    for (int i = 0; i < 300; i++) step(1'b1, bad_frame(), 1'b0, 1'b1, 1'b0);
    check("t4_sat", err_count, 8'hFF);

    // Repeat exactly on the timeout edge wins; frame masks a simultaneous repeat.
    step(1'b1, mk_frame(ADDR, 8'h07), 1'b0, 1'b1, 1'b0);
    idle(HOLD - 1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("tc_kind", key_kind, K_REPEAT);
    check("tc_held", held, 1);
    step(1'b1, mk_frame(ADDR, 8'h07), 1'b1, 1'b1, 1'b0);
    check("tc_same_kind", key_kind, K_REPEAT);
    step(1'b1, mk_frame(ADDR, 8'h45), 1'b1, 1'b1, 1'b0);
    check("tc_new_kind", key_kind, K_RELEASE);
    idle(2, 1'b1);

    // Overflow: six events into a four-deep FIFO.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00FF45BA, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("t5_ovf", overflow, 1);
    drain_kind = '{K_PRESS, K_REPEAT, K_REPEAT, K_REPEAT};
    for (int i = 0; i < 4; i++) begin
      check("t5_drain_kind", key_kind, drain_kind[i]);
      check("t5_drain_code", key_code, 8'h45);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    check("t5_empty", key_valid, 0);

    // Reset mid-hold flushes and never produces a release.
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("mr_valid", key_valid, 0);
    check("mr_held", held, 0);
    idle(HOLD + 5, 1'b1);

`ifdef IR_ADDR_FILTER_EN
    step(1'b1, 32'h10EF45BA, 1'b0, 1'b1, 1'b0);
    check("t6_filtered", key_valid, 0);
    check("t6_err", err_count, 0);
    step(1'b1, 32'h00FF45BA, 1'b0, 1'b1, 1'b0);
    check("t6_press", key_kind, K_PRESS);
    check("t6_valid", key_valid, 1);
    idle(HOLD + 2, 1'b1);
`endif

    // Random segments of varying strobe density and consumer readiness.
    for (int s = 0; s < 25; s++) begin
      int len, dens, rdy_pct;
      logic [7:0] pool [4];
      len     = $urandom_range(200, 2500);
      dens    = (s % 4 == 0) ? 3 : (s % 4 == 1) ? 20 : (s % 4 == 2) ? 300 : 2000;
      rdy_pct = $urandom_range(10, 100);
      pool    = '{8'h45, 8'h16, 8'h07, 8'($urandom)};
      for (int i = 0; i < len; i++) begin
        logic fv, rv, rdy;
        logic [31:0] fr;
        logic [7:0]  a;
        int kind;
        fv = 0; rv = 0; fr = 32'h0;
        rdy = ($urandom_range(99) < rdy_pct);
`ifdef IR_ADDR_FILTER_EN
        a = ($urandom_range(3) == 0) ? 8'($urandom) : ADDR;
`else
        a = 8'($urandom);
`endif
        if (!m_switch && $urandom_range(dens - 1) == 0) begin
          kind = $urandom_range(99);
          if (kind < 40) rv = 1;
          else if (kind < 75) begin fv = 1; fr = mk_frame(a, pool[$urandom_range(3)]); end
          else if (kind < 90) begin fv = 1; fr = bad_frame(); end
          else begin fv = 1; rv = 1; fr = mk_frame(a, pool[$urandom_range(3)]); end
        end
        step(fv, fr, rv, rdy, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
